// File: rtl/int_mul_dispatch.sv
// rtl/int_mul_dispatch.sv - in-order operand FIFO and four-phase req/ack issue stage for the iterative multiplier
// Optional zero-operand bypass: INT_MUL_DISPATCH_ZERO_BYPASS_EN
module int_mul_dispatch #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mul_req,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_out,
  input  logic             mul_ack,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_a_d [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [WIDTH-1:0] mem_b_d [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];
  logic [TAG_W-1:0] mem_tag_d [DEPTH];
  logic             mul_req_q, mul_req_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;

  logic             full, empty, push, zero_head;
  logic [WIDTH-1:0] head_a, head_b;
  logic [TAG_W-1:0] head_tag;

  // Same index bits with differing wrap bit means the writer is a full lap ahead.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head_a   = mem_a_q[rd_ptr_q[AW-1:0]];
  assign head_b   = mem_b_q[rd_ptr_q[AW-1:0]];
  assign head_tag = mem_tag_q[rd_ptr_q[AW-1:0]];

`ifdef INT_MUL_DISPATCH_ZERO_BYPASS_EN
  assign zero_head = (head_a == '0) || (head_b == '0);
`else
  assign zero_head = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_a_d     = mem_a_q;
    mem_b_d     = mem_b_q;
    mem_tag_d   = mem_tag_q;
    mul_req_d   = mul_req_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    iss_tag_d   = iss_tag_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;

    if (push) begin
      mem_a_d[wr_ptr_q[AW-1:0]]   = in_a;
      mem_b_d[wr_ptr_q[AW-1:0]]   = in_b;
      mem_tag_d[wr_ptr_q[AW-1:0]] = in_tag;
      wr_ptr_d                    = wr_ptr_q + (AW+1)'(1);
    end

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!empty && !res_valid_q) begin
          rd_ptr_d = rd_ptr_q + (AW+1)'(1);
          if (zero_head) begin
            res_data_d  = '0;
            res_tag_d   = head_tag;
            res_valid_d = 1'b1;
          end else begin
            mul_a_d   = head_a;
            mul_b_d   = head_b;
            iss_tag_d = head_tag;
            mul_req_d = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        if (mul_ack) begin
          res_data_d  = mul_out;
          res_tag_d   = iss_tag_q;
          res_valid_d = 1'b1;
          mul_req_d   = 1'b0;
          state_d     = DROP;
        end
      end
      DROP: begin
        if (!mul_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_a_q     <= '{default: '0};
      mem_b_q     <= '{default: '0};
      mem_tag_q   <= '{default: '0};
      mul_req_q   <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      iss_tag_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_a_q     <= mem_a_d;
      mem_b_q     <= mem_b_d;
      mem_tag_q   <= mem_tag_d;
      mul_req_q   <= mul_req_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      iss_tag_q   <= iss_tag_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
    end
  end

  assign mul_req   = mul_req_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign busy      = !empty || (state_q != IDLE) || res_valid_q;

endmodule

// File: tb/tb_int_mul_dispatch.sv
// tb/tb_int_mul_dispatch.sv - self-checking bench for int_mul_dispatch with a behavioural multiplier and scoreboard
module tb_int_mul_dispatch;
  localparam int DEPTH = 4;
`ifdef INT_MUL_DISPATCH_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        mul_req;
  logic [31:0] mul_a, mul_b;
  logic [31:0] mul_out = '0;
  logic        mul_ack = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [3:0]  res_tag;
  logic        busy;

  int_mul_dispatch #(.WIDTH(32), .TAG_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
    .mul_out(mul_out), .mul_ack(mul_ack),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Multiplier: fixed or random latency, random garbage on mul_out except at ack.
  int          lat_fixed = 3;
  bit          lat_rand  = 1'b0;
  int          mst = 0, mcnt = 0;
  logic [63:0] mp;
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      mst = 0;
      mul_ack = 1'b0;
    end else begin
      case (mst)
        0: if (mul_req) begin
             mcnt = lat_rand ? int'($urandom_range(0, 5)) : lat_fixed;
             mul_out = $urandom;
             mst = 1;
           end
        1: if (mcnt == 0) begin
             mp = 64'(mul_a) * 64'(mul_b);
             mul_out = mp[31:0];
             mul_ack = 1'b1;
             mst = 2;
           end else mcnt--;
        2: if (!mul_req) begin
             mul_out = $urandom;
             mcnt = int'($urandom_range(0, 2));
             mst = 3;
           end
        default: if (mcnt == 0) begin
             mul_ack = 1'b0;
             mst = 0;
           end else mcnt--;
      endcase
    end
  end

  // res_ready pattern: 0 = held by main, 1 = toggle, 2 = random
  int rr_mode = 0;
  always begin
    @(posedge clk);
    #1;
    if (rr_mode == 1) res_ready = ~res_ready;
    else if (rr_mode == 2) res_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard and protocol monitors sample mid-cycle.
  logic [35:0] exp_q[$];
  logic [35:0] e;
  logic [63:0] sp;
  int          pops = 0, req_rises = 0;
  logic        prev_req = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
  logic [31:0] pa, pb, pdata;
  logic [3:0]  ptag;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_req = 1'b0;
      prev_rv  = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        sp = 64'(in_a) * 64'(in_b);
        exp_q.push_back({in_tag, sp[31:0]});
      end
      if (res_valid && prev_rv && !prev_rr) begin
        chk("res_stable", {ptag, pdata}, {res_tag, res_data});
      end
      if (res_valid && res_ready) begin
        pops++;
        if (exp_q.size() == 0) chk("sb_spurious", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sb_data", res_data, e[31:0]);
          chk("sb_tag", res_tag, e[35:32]);
        end
      end
      if (mul_req && !prev_req) begin
        req_rises++;
        chk("req_while_ack", mul_ack, 0);
      end
      if (mul_req && prev_req) chk("opnd_stable", {mul_a, mul_b}, {pa, pb});
      prev_req = mul_req;
      prev_rv  = res_valid;
      prev_rr  = res_ready;
    end
    pa = mul_a; pb = mul_b; pdata = res_data; ptag = res_tag;
  end

  // Call at posedge+1; leaves in_valid high if not accepted.
  task automatic try_push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                          input int limit, output bit acc);
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
    acc = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (acc) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    bit acc;
    try_push(a, b, t, 2000, acc);
    if (!acc) begin
      chk("push_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_res(output logic [31:0] d, output logic [3:0] t);
    bit got = 1'b0;
    d = '0; t = '0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (res_valid) begin
        got = 1'b1; d = res_data; t = res_tag;
        break;
      end
    end
    if (!got) chk("res_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !mul_ack) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", ok, 1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[7];

  initial begin
    logic [31:0] d;
    logic [3:0]  t;
    bit          acc;
    int          r0, p0;
    logic [31:0] ra, rb;

    vecs[0] = '{32'h0001_0003, 32'd5,         4'd1, 32'h0005_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 32'h0000_0001};
    vecs[2] = '{32'd0,         32'd123,       4'd3, 32'd0};
    vecs[3] = '{32'd2,         32'd2,         4'd4, 32'd4};
    vecs[4] = '{32'h8000_0000, 32'd2,         4'd5, 32'd0};
    vecs[5] = '{32'd12345,     32'd6789,      4'd6, 32'd83810205};
    vecs[6] = '{32'hDEAD_BEEF, 32'd0,         4'd8, 32'd0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mul_req", mul_req, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res", {res_tag, res_data}, 0);
    chk("rst_mul_ab", {mul_a, mul_b}, 0);
    rst = 1'b0;

    // Reset in the middle of a handshake
    lat_fixed = 20;
    push(32'd7, 32'd9, 4'd0);
    @(posedge clk);
    #2;
    chk("req_before_rst", mul_req, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_mul_req", mul_req, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_mul_ab", {mul_a, mul_b}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat_fixed = 3;
    res_ready = 1'b1;
    push(32'd3, 32'd4, 4'd2);
    wait_res(d, t);
    chk("post_rst_data", d, 12);
    chk("post_rst_tag", t, 2);
    wait_idle();

    // Table: one op at a time from an idle dispatcher
    for (int i = 0; i < 7; i++) begin
      bit zb;
      zb = BYP && (vecs[i].a == 0 || vecs[i].b == 0);
      lat_fixed = (i == 0) ? 17 : 2;
      p0 = req_rises;
      push(vecs[i].a, vecs[i].b, vecs[i].tag);
      chk("req_not_yet", mul_req, 0);
      @(posedge clk);
      #1;
      chk("req_after_1", mul_req, !zb);
      if (zb) chk("bypass_res_valid", res_valid, 1);
      wait_res(d, t);
      chk("vec_data", d, vecs[i].exp);
      chk("vec_tag", t, vecs[i].tag);
      chk("req_low_at_res", mul_req, 0);
      wait_idle();
      chk("vec_req_pulses", req_rises - p0, zb ? 0 : 1);
    end

    // Zero bypass back-to-back sequence
    p0 = req_rises;
    r0 = pops;
    push(32'd0, 32'd123, 4'd3);
    push(32'd2, 32'd2, 4'd4);
    wait_idle();
    chk("zb_req_pulses", req_rises - p0, BYP ? 1 : 2);
    chk("zb_results", pops - r0, 2);

    // Fill and stall: one op issued plus DEPTH buffered, then blocked
    lat_fixed = 3;
    res_ready = 1'b0;
    r0 = pops;
    for (int i = 0; i < DEPTH + 2; i++) begin
      try_push(32'(i + 1), 32'd1, 4'(i), 20, acc);
      chk("fill_accept", acc, i < DEPTH + 1);
    end
    chk("fill_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    try_push(32'(DEPTH + 2), 32'd1, 4'(DEPTH + 1), 200, acc);
    chk("fill_late_accept", acc, 1);
    wait_idle();
    chk("fill_results", pops - r0, DEPTH + 2);

    // Wrap-around with toggling res_ready and random latency
    lat_rand = 1'b1;
    rr_mode = 1;
    r0 = pops;
    for (int i = 0; i < 3 * DEPTH; i++) push(32'(i), 32'(i + 1), 4'(i));
    wait_idle();
    chk("wrap_results", pops - r0, 3 * DEPTH);

    // Random operands, some zero, random consumer
    rr_mode = 2;
    r0 = pops;
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      push(ra, rb, 4'($urandom));
    end
    rr_mode = 0;
    res_ready = 1'b1;
    wait_idle();
    chk("rand_results", pops - r0, 40);
    chk("end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
